// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Register file with two combinational read ports, a byte-enabled
//            write port with same-cycle bypass, and a per-register busy
//            scoreboard with a registered pending-count.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      ra1,
    input  logic [AW-1:0]      ra2,
    output logic [WIDTH-1:0]   rd1,
    output logic [WIDTH-1:0]   rd2,
    input  logic               wen,
    input  logic [AW-1:0]      wa,
    input  logic [WIDTH-1:0]   wd,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic               rsv_en,
    input  logic [AW-1:0]      rsv_addr,
    output logic               busy1,
    output logic               busy2,
    output logic               hazard,
    output logic [AW:0]        pending
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_pending;

    logic             w_wr;
    logic             w_rsv;
    logic [WIDTH-1:0] w_wmerged;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [AW:0]      w_count;
    logic             w_byp1;
    logic             w_byp2;

    // Address 0 is never written or reserved, so r_mem[0] and r_busy[0] stay 0.
    assign w_wr  = wen && (wa != '0);
    assign w_rsv = rsv_en && (rsv_addr != '0);

    always_comb begin
        w_wmerged = r_mem[wa];
        for (int i = 0; i < NB; i++) begin
            if (wbe[i]) begin
                w_wmerged[8*i +: 8] = wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_wr) begin
            r_mem[wa] <= w_wmerged;
        end
    end

    // Reservation is applied after the clear so a new producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr) begin
            w_busy_nxt[wa] = 1'b0;
        end
        if (w_rsv) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        w_count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_count = w_count + {{AW{1'b0}}, w_busy_nxt[k]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_pending <= w_count;
        end
    end

    assign w_byp1 = w_wr && (wa == ra1);
    assign w_byp2 = w_wr && (wa == ra2);

    assign rd1 = w_byp1 ? w_wmerged : r_mem[ra1];
    assign rd2 = w_byp2 ? w_wmerged : r_mem[ra2];

    // A forwarded read is not busy unless the same cycle reserves it again.
    assign busy1 = r_busy[ra1] & ~(w_byp1 & ~(rsv_en && (rsv_addr == ra1)));
    assign busy2 = r_busy[ra2] & ~(w_byp2 & ~(rsv_en && (rsv_addr == ra2)));

    assign hazard  = busy1 | busy2;
    assign pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Scoreboard bench for regfile_sb against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [AW-1:0]    ra1, ra2, wa, rsv_addr;
    logic [WIDTH-1:0] rd1, rd2, wd;
    logic             wen, rsv_en, busy1, busy2, hazard;
    logic [3:0]       wbe;
    logic [AW:0]      pending;

    regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wen(wen), .wa(wa), .wd(wd), .wbe(wbe), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .busy1(busy1), .busy2(busy2), .hazard(hazard),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic        hz;
        logic [5:0]  pend;
    } exp_t;

    exp_t        q[$];
    event        ev;
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] m_mem  [DEPTH];
    bit          m_busy [DEPTH];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    endtask

    function automatic void model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = 32'h0;
            m_busy[k] = 1'b0;
        end
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int k = 0; k < DEPTH; k++) c += m_busy[k] ? 1 : 0;
        return c;
    endfunction

    function automatic logic [31:0] exp_read(input int a);
        logic [31:0] v;
        if (a == 0) return 32'h0;
        v = m_mem[a];
        if (wen && int'(wa) == a)
            for (int i = 0; i < 4; i++) if (wbe[i]) v[8*i +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
        if (wen && int'(wa) == a && !(rsv_en && int'(rsv_addr) == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic void model_update();
        int w = int'(wa);
        int r = int'(rsv_addr);
        if (wen && w != 0) begin
            m_mem[w]  = exp_read(w);
            m_busy[w] = 1'b0;
        end
        if (rsv_en && r != 0) m_busy[r] = 1'b1;
    endfunction

    task automatic drive(input bit we, input int aw, input logic [31:0] d, input logic [3:0] be,
                         input bit rs, input int ar, input int r1, input int r2);
        wen = we; wa = aw[AW-1:0]; wd = d; wbe = be;
        rsv_en = rs; rsv_addr = ar[AW-1:0];
        ra1 = r1[AW-1:0]; ra2 = r2[AW-1:0];
    endtask

    task automatic idle(input int r1, input int r2);
        drive(1'b0, 0, 32'h0, 4'h0, 1'b0, 0, r1, r2);
    endtask

    // Push the expected response for the current inputs and hand it to the monitor.
    task automatic sample();
        exp_t e;
        #1;
        e.rd1  = exp_read(int'(ra1));
        e.rd2  = exp_read(int'(ra2));
        e.b1   = exp_busy(int'(ra1));
        e.b2   = exp_busy(int'(ra2));
        e.hz   = e.b1 | e.b2;
        e.pend = 6'(model_count());
        q.push_back(e);
        -> ev;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(0, 0);
        model_clear();
        sample();
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_hazard", 32'(hazard), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    always begin
        exp_t e;
        @(ev);
        #1;
        if (q.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("rd1", rd1, e.rd1);
            chk("rd2", rd2, e.rd2);
            chk("busy1", 32'(busy1), 32'(e.b1));
            chk("busy2", 32'(busy2), 32'(e.b2));
            chk("hazard", 32'(hazard), 32'(e.hz));
            chk("pending", 32'(pending), 32'(e.pend));
        end
    end

    initial begin
        reset = 1'b0;
        idle(0, 0);
        model_clear();
        @(negedge clk);
        sample();
        @(negedge clk);
        reset = 1'b1;

        // Byte-enable write with bypass
        drive(1, 5, 32'hFFFFFFFF, 4'hF, 0, 0, 5, 0); sample(); step();
        drive(1, 5, 32'h12345678, 4'b0101, 0, 0, 5, 5); sample();
        chk("be_bypass", rd1, 32'hFF34FF78);
        step();
        idle(5, 0); sample();
        chk("be_stored", rd1, 32'hFF34FF78);
        step();

        // Register 0 ignores writes and reservations
        drive(1, 0, 32'hDEADBEEF, 4'hF, 1, 0, 0, 0); sample();
        chk("r0_bypass", rd1, 32'h0);
        step();
        idle(0, 0); sample();
        chk("r0_busy", 32'(busy1), 32'd0);
        chk("r0_pending", 32'(pending), 32'd0);
        step();

        // Reserve then write back r3
        drive(0, 0, 32'h0, 4'h0, 1, 3, 3, 0); sample(); step();
        idle(3, 0); sample();
        chk("r3_busy", 32'(busy1), 32'd1);
        chk("r3_pending", 32'(pending), 32'd1);
        step();
        drive(1, 3, 32'hA5A5_0001, 4'hF, 0, 0, 3, 3); sample();
        chk("r3_wb_mask", 32'(busy1), 32'd0);
        chk("r3_wb_data", rd1, 32'hA5A5_0001);
        step();
        idle(3, 0); sample();
        chk("r3_cleared", 32'(pending), 32'd0);
        step();

        // Simultaneous reserve and write to same and to different registers
        drive(0, 0, 32'h0, 4'h0, 1, 7, 0, 0); sample(); step();
        drive(1, 7, 32'h0000_7777, 4'hF, 1, 7, 7, 0); sample(); step();
        idle(7, 0); sample();
        chk("r7_still_busy", 32'(busy1), 32'd1);
        chk("r7_pending", 32'(pending), 32'd1);
        step();
        drive(0, 0, 32'h0, 4'h0, 1, 9, 0, 0); sample(); step();
        drive(1, 9, 32'h9999_0000, 4'h3, 1, 2, 2, 9); sample(); step();
        idle(2, 9); sample();
        chk("r2_busy", 32'(busy1), 32'd1);
        chk("r9_free", 32'(busy2), 32'd0);
        chk("swap_pending", 32'(pending), 32'd2);
        step();

        // Reset mid-run discards reservations and data
        do_reset();
        for (int k = 1; k < DEPTH; k++) begin
            idle(k, DEPTH - k); sample(); step();
        end

        // Fill and drain the scoreboard
        for (int k = 1; k < DEPTH; k++) begin
            drive(0, 0, 32'h0, 4'h0, 1, k, k, 0); sample(); step();
        end
        idle(1, 31); sample();
        chk("full_pending", 32'(pending), 32'd31);
        step();
        for (int k = 1; k < DEPTH; k++) begin
            drive(1, k, $urandom, 4'hF, 0, 0, k, k - 1); sample(); step();
        end
        idle(1, 31); sample();
        chk("drained_pending", 32'(pending), 32'd0);
        step();

        // Randomized traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            int aw = $urandom_range(0, DEPTH - 1);
            int r1 = ($urandom % 4 == 0) ? aw : $urandom_range(0, DEPTH - 1);
            int r2 = ($urandom % 4 == 0) ? r1 : $urandom_range(0, DEPTH - 1);
            int ar = ($urandom % 5 == 0) ? aw : $urandom_range(0, DEPTH - 1);
            if (i == 200) do_reset();
            drive($urandom_range(0, 1), aw, $urandom, 4'($urandom), ($urandom % 3 == 0), ar, r1, r2);
            sample();
            step();
        end

        #5;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
